commit_bus_arbiter: RTL

- Far end of the station commit handshake. Collects commit requests and commit packets from up to NUM_STATIONS reservation stations (division, adder, multiplier, ...).
- Grants exactly one station at a time, round-robin, then broadcasts the granted packet on the module commit bus with a valid bit.
- The bus feeds every station's iCommitBus (operand snooping) and the register file write port.

---
 rtl/commit_bus_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/commit_bus_arbiter.sv
// Commit bus arbiter: grants one reservation station at a time and broadcasts its packet with a valid bit.
// Define COMMIT_ARB_FIXED_PRIORITY_EN for a lowest-index-wins build with no rotating pointer.
module commit_bus_arbiter #(
    parameter int unsigned NUM_STATIONS = 4,
    parameter int unsigned PACKET_W     = 114,
    parameter int unsigned PTR_W        = 2
) (
    input  logic                             Clock,
    input  logic                             Reset,
    input  logic [NUM_STATIONS-1:0]          iCommitRequest,
    input  logic [NUM_STATIONS*PACKET_W-1:0] iCommitData,
    output logic [NUM_STATIONS-1:0]          oCommitGranted,
    output logic [PACKET_W:0]                oCommitBus,
    output logic                             oBusy
);

    typedef enum logic [0:0] {
        S_ARB    = 1'b0,
        S_COMMIT = 1'b1
    } arbState_t;

    arbState_t               state;
    logic [PACKET_W-1:0]     rPacket;
    logic [PTR_W-1:0]        winnerIdx;
    logic [NUM_STATIONS-1:0] winnerOneHot;
    logic [PACKET_W-1:0]     winnerPacket;
    logic                    anyRequest;

    assign anyRequest = |iCommitRequest;
    assign oBusy      = (state == S_COMMIT) || anyRequest;

    function automatic logic [PTR_W-1:0] lowestSet(input logic [NUM_STATIONS-1:0] vec);
        lowestSet = '0;
        for (int i = int'(NUM_STATIONS) - 1; i >= 0; i--) begin
            if (vec[i]) lowestSet = PTR_W'(i);
        end
    endfunction

`ifdef COMMIT_ARB_FIXED_PRIORITY_EN
    always_comb begin
        winnerIdx = lowestSet(iCommitRequest);
    end
`else
    logic [PTR_W-1:0]        ptr;
    logic [PTR_W-1:0]        rWinner;
    logic [NUM_STATIONS-1:0] upperMask;
    logic [NUM_STATIONS-1:0] upperRequest;

    // Requests at or above the pointer win first; otherwise wrap to the lowest index.
    always_comb begin
        upperMask = '0;
        for (int i = 0; i < int'(NUM_STATIONS); i++) begin
            upperMask[i] = (PTR_W'(i) >= ptr);
        end
        upperRequest = iCommitRequest & upperMask;
        winnerIdx    = (|upperRequest) ? lowestSet(upperRequest) : lowestSet(iCommitRequest);
    end
`endif

    // Decode the winner into its one-hot grant and its packet slice.
    always_comb begin
        winnerOneHot = '0;
        winnerPacket = '0;
        for (int i = 0; i < int'(NUM_STATIONS); i++) begin
            if (winnerIdx == PTR_W'(i)) begin
                winnerOneHot[i] = 1'b1;
                winnerPacket    = iCommitData[i*PACKET_W +: PACKET_W];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state          <= S_ARB;
            oCommitGranted <= '0;
            oCommitBus     <= '0;
            rPacket        <= '0;
`ifndef COMMIT_ARB_FIXED_PRIORITY_EN
            ptr            <= '0;
            rWinner        <= '0;
`endif
        end else begin
            unique case (state)
                S_ARB: begin
                    oCommitBus[PACKET_W] <= 1'b0;
                    if (anyRequest) begin
                        oCommitGranted <= winnerOneHot;
                        rPacket        <= winnerPacket;
`ifndef COMMIT_ARB_FIXED_PRIORITY_EN
                        rWinner        <= winnerIdx;
`endif
                        state          <= S_COMMIT;
                    end else begin
                        oCommitGranted <= '0;
                    end
                end
                S_COMMIT: begin
                    // Requests are ignored here; the winner drops its request at this edge.
                    oCommitGranted <= '0;
                    oCommitBus     <= {1'b1, rPacket};
`ifndef COMMIT_ARB_FIXED_PRIORITY_EN
                    ptr            <= (rWinner == PTR_W'(NUM_STATIONS - 1)) ? '0 : rWinner + 1'b1;
`endif
                    state          <= S_ARB;
                end
                default: begin
                    state <= S_ARB;
                end
            endcase
        end
    end

endmodule
